// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one ALU between N_REQ requesters. A round-robin arbiter picks a
//   requester in IDLE, the latched operation is driven onto the ALU port with
//   inp_valid=2'b11 for the command's fixed latency, and the ALU result and
//   flags are captured and returned tagged with the requester id.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/req_ready        per-requester request, one-hot accept pulse
//   req_mode/cmd/opa/opb/cin   per-requester payload, requester i at [i*W +: W]
//   alu_ce, alu_inp_valid      ALU enable, 2'b11 while an op is in flight
//   alu_mode/cmd/opa/opb/cin   latched payload to the ALU
//   alu_res, alu_err..alu_e    ALU result and flags
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_res/rsp_flags   served requester, captured result, {err,oflow,cout,g,l,e}
//   rsp_drop                   1-cycle pulse when a stalled response is dropped
//
// Configuration
//   ALU_RSP_TIMEOUT_EN  when defined, a response left unaccepted for RSP_TIMEOUT
//                       cycles is dropped and the arbiter returns to IDLE.
//                       When undefined, responses are held indefinitely and
//                       rsp_drop is tied low.

module alu_req_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int DATA_W      = 8,
    parameter  int CMD_W       = 4,
    parameter  int RES_LAT     = 1,
    parameter  int MUL_LAT     = 2,
    parameter  int RSP_TIMEOUT = 16,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_mode,
    input  logic [N_REQ*CMD_W-1:0]  req_cmd,
    input  logic [N_REQ*DATA_W-1:0] req_opa,
    input  logic [N_REQ*DATA_W-1:0] req_opb,
    input  logic [N_REQ-1:0]        req_cin,
    output logic                    alu_ce,
    output logic [1:0]              alu_inp_valid,
    output logic                    alu_mode,
    output logic [CMD_W-1:0]        alu_cmd,
    output logic [DATA_W-1:0]       alu_opa,
    output logic [DATA_W-1:0]       alu_opb,
    output logic                    alu_cin,
    input  logic [DATA_W:0]         alu_res,
    input  logic                    alu_err,
    input  logic                    alu_oflow,
    input  logic                    alu_cout,
    input  logic                    alu_g,
    input  logic                    alu_l,
    input  logic                    alu_e,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W:0]         rsp_res,
    output logic [5:0]              rsp_flags,
    output logic                    rsp_drop
);

    if (N_REQ < 2 || RES_LAT < 1 || MUL_LAT < 1 || RSP_TIMEOUT < 1) begin : g_param_chk
        $error("alu_req_arbiter: illegal parameter value");
    end

    localparam int MAX_LAT = (MUL_LAT > RES_LAT) ? MUL_LAT : RES_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              mode;
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic              cin;
        logic [ID_W-1:0]   id;
    } req_t;

    state_t           state, state_nxt;
    req_t             cur, win_req;
    logic [ID_W-1:0]  rr_ptr, win_id;
    logic             win_vld;
    logic [CNT_W-1:0] cnt, lat;
    logic             is_mul;
    logic             to_hit;

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_req.mode = req_mode[win_id];
        win_req.cmd  = req_cmd[win_id*CMD_W +: CMD_W];
        win_req.opa  = req_opa[win_id*DATA_W +: DATA_W];
        win_req.opb  = req_opb[win_id*DATA_W +: DATA_W];
        win_req.cin  = req_cin[win_id];
        win_req.id   = win_id;
    end

    // INC_MUL (9) and SHIFT_MUL (10) in arithmetic mode use the longer latency.
    assign is_mul = cur.mode && (cur.cmd == CMD_W'(9) || cur.cmd == CMD_W'(10));
    assign lat    = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(RES_LAT);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)            state_nxt = ISSUE;
            ISSUE:                           state_nxt = WAIT;
            WAIT:    if (cnt == CNT_W'(1))   state_nxt = RESP;
            RESP:    if (rsp_ready || to_hit) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        alu_ce    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            // Grant is gated by reset so nothing is accepted in a reset cycle.
            IDLE:        if (win_vld && !reset) req_ready[win_id] = 1'b1;
            ISSUE, WAIT: alu_ce    = 1'b1;
            RESP:        rsp_valid = 1'b1;
            default: ;
        endcase
        alu_inp_valid = {2{alu_ce}};
    end

    // ------------------------------------------------------------------
    // Datapath: payload latch, pointer, latency counter, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    cur    <= win_req;
                    rr_ptr <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
                end
                ISSUE: cnt <= lat;
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_res   <= alu_res;
                        rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_mode = cur.mode;
    assign alu_cmd  = cur.cmd;
    assign alu_opa  = cur.opa;
    assign alu_opb  = cur.opb;
    assign alu_cin  = cur.cin;
    assign rsp_id   = cur.id;

    // ------------------------------------------------------------------
    // Optional stalled-response timeout
    // ------------------------------------------------------------------
`ifdef ALU_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    // Hit on the RSP_TIMEOUT-th consecutive stalled cycle of this response.
    assign to_hit = (state == RESP) && !rsp_ready && (to_cnt == TO_W'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt   <= '0;
            rsp_drop <= 1'b0;
        end else begin
            rsp_drop <= to_hit;
            if (state == RESP && !rsp_ready && !to_hit) to_cnt <= to_cnt + 1'b1;
            else                                        to_cnt <= '0;
        end
    end
`else
    assign to_hit   = 1'b0;
    assign rsp_drop = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_mode = '0;
    logic [N*CW-1:0]   req_cmd = '0;
    logic [N*DW-1:0]   req_opa = '0;
    logic [N*DW-1:0]   req_opb = '0;
    logic [N-1:0]      req_cin = '0;
    logic              alu_ce;
    logic [1:0]        alu_inp_valid;
    logic              alu_mode;
    logic [CW-1:0]     alu_cmd;
    logic [DW-1:0]     alu_opa, alu_opb;
    logic              alu_cin;
    logic [DW:0]       alu_res;
    logic              alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [DW:0]       rsp_res;
    logic [5:0]        rsp_flags;
    logic              rsp_drop;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
        .alu_ce(alu_ce), .alu_inp_valid(alu_inp_valid), .alu_mode(alu_mode),
        .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
        .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_drop(rsp_drop)
    );

    // Tiny ALU: ADD, INC_MUL, logic AND; anything else raises err.
    // Output is zero unless both operands are marked valid.
    always_comb begin
        alu_res   = '0;
        alu_err   = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_l     = 1'b0;
        alu_e     = 1'b0;
        if (alu_inp_valid == 2'b11) begin
            if (alu_mode) begin
                case (alu_cmd)
                    4'd0:    alu_res = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'd0, alu_cin};
                    4'd9:    alu_res = ({1'b0, alu_opa} + 9'd1) * ({1'b0, alu_opb} + 9'd1);
                    default: alu_err = 1'b1;
                endcase
            end else begin
                case (alu_cmd)
                    4'd0:    alu_res = {1'b0, alu_opa & alu_opb};
                    default: alu_err = 1'b1;
                endcase
            end
        end
        alu_cout = alu_res[DW];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic m, input logic [CW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_mode[i]            = m;
        req_cmd[i*CW +: CW]    = c;
        req_opa[i*DW +: DW]    = a;
        req_opb[i*DW +: DW]    = b;
        req_cin[i]             = 1'b0;
    endtask

    initial begin
        int n;

        // ---- reset state, with requests pending ----
        req_valid = 4'b1111;
        cyc(); cyc(); #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_ce", alu_ce, 0);
        chk("rst_ivld", alu_inp_valid, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_res", rsp_res, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_drop", rsp_drop, 0);

        // ---- 1: single requester 2, ADD 0F+01 ----
        cyc();
        reset = 1'b0;
        req_valid = 4'b0100;
        set_req(2, 1'b1, 4'd0, 8'h0F, 8'h01);
        #1;
        chk("t1_grant", req_ready, 4'b0100);
        chk("t1_ce_idle", alu_ce, 0);
        cyc(); req_valid = '0; #1;                   // Tg+1
        chk("t1_ivld", alu_inp_valid, 2'b11);
        chk("t1_opa", alu_opa, 8'h0F);
        chk("t1_ready_off", req_ready, 0);
        cyc(); #1;                                   // Tg+2
        chk("t1_no_rsp_yet", rsp_valid, 0);
        chk("t1_ce_wait", alu_ce, 1);
        cyc(); #1;                                   // Tg+3
        chk("t1_rsp", rsp_valid, 1);
        chk("t1_id", rsp_id, 2);
        chk("t1_res", rsp_res, 9'h010);
        chk("t1_flags", rsp_flags, 0);
        chk("t1_ce_resp", alu_ce, 0);
        chk("t1_ivld_resp", alu_inp_valid, 0);
        cyc(); #1;
        chk("t1_rsp_done", rsp_valid, 0);

        // ---- 2: all requesting, round robin 0,1,2,3,0 from reset ----
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd0, 8'(i * 16 + 1), 8'h02);
        req_valid = 4'b1111;
        cyc();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            chk("t2_ready", req_ready, (c % 4 == 0) ? (32'd1 << ((c / 4) % 4)) : 32'd0);
            chk("t2_rsp", rsp_valid, (c % 4 == 3) ? 32'd1 : 32'd0);
            if (c % 4 == 3) begin
                chk("t2_id", rsp_id, (c / 4) % 4);
                chk("t2_res", rsp_res, ((c / 4) % 4) * 16 + 3);
            end
            cyc(); #1;
        end
        req_valid = '0;

        // ---- 3: INC_MUL 3,4 on requester 1 (ptr now 1) ----
        req_valid = 4'b0010;
        set_req(1, 1'b1, 4'd9, 8'd3, 8'd4);
        #1;
        chk("t3_grant", req_ready, 4'b0010);
        cyc(); req_valid = '0;                       // Tg+1
        cyc();                                       // Tg+2
        cyc(); rsp_ready = 1'b0; #1;                 // Tg+3
        chk("t3_no_rsp_tg3", rsp_valid, 0);
        cyc(); req_valid = 4'b1111; #1;              // Tg+4
        chk("t3_rsp", rsp_valid, 1);
        chk("t3_res", rsp_res, 9'h014);

        // ---- 4: response stalled 5 cycles ----
        for (int k = 0; k < 5; k++) begin
            chk("t4_valid", rsp_valid, 1);
            chk("t4_id", rsp_id, 1);
            chk("t4_res", rsp_res, 9'h014);
            chk("t4_ce", alu_ce, 0);
            chk("t4_ready", req_ready, 0);
            chk("t4_drop", rsp_drop, 0);
            cyc(); #1;
        end
        rsp_ready = 1'b1; #1;
        chk("t4_still_valid", rsp_valid, 1);
        cyc(); #1;
        chk("t4_next_grant", req_ready, 4'b0100);

        // ---- 5: reset during WAIT ----
        cyc(); req_valid = '0;                       // G+1 ISSUE
        cyc(); reset = 1'b1; #1;                     // G+2 WAIT
        chk("t5_in_wait", alu_ce, 1);
        cyc(); reset = 1'b0; #1;                     // G+3
        chk("t5_ready", req_ready, 0);
        chk("t5_ce", alu_ce, 0);
        chk("t5_ivld", alu_inp_valid, 0);
        chk("t5_opa", alu_opa, 0);
        chk("t5_mode", alu_mode, 0);
        chk("t5_rsp", rsp_valid, 0);
        chk("t5_res", rsp_res, 0);
        chk("t5_id", rsp_id, 0);
        cyc();                                       // G+4
        chk("t5_no_late_rsp", rsp_valid, 0);
        req_valid = 4'b1111;
        set_req(0, 1'b1, 4'd15, 8'h55, 8'h0A);       // invalid cmd -> err
        #1;
        chk("t5_grant_from0", req_ready, 4'b0001);

        // ---- err passthrough ----
        cyc(); req_valid = '0;
        cyc();
        cyc(); #1;
        chk("err_rsp", rsp_valid, 1);
        chk("err_id", rsp_id, 0);
        chk("err_flags", rsp_flags, 6'b100000);
        chk("err_res", rsp_res, 0);
        cyc(); #1;
        chk("err_done", rsp_valid, 0);

`ifdef ALU_RSP_TIMEOUT_EN
        // ---- 6: stalled response dropped after 16 cycles ----
        rsp_ready = 1'b0;
        req_valid = 4'b0110;                         // ptr=1 -> requester 1 wins
        cyc(); req_valid = 4'b0100;
        n = 0;
        while (!rsp_valid && n < 10) begin
            cyc(); n++;
        end
        chk("t6_rise", rsp_valid, 1);
        repeat (16) cyc();
        #1;
        chk("t6_drop", rsp_drop, 1);
        chk("t6_valid_off", rsp_valid, 0);
        chk("t6_pending_grant", req_ready, 4'b0100);
        cyc(); req_valid = '0; #1;
        chk("t6_drop_pulse", rsp_drop, 0);
`else
        n = 0;
        chk("drop_tied", rsp_drop, n);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
